// File: rtl/mem_check_pkg.sv
// Shared types for the data-memory self-check scoreboard: compare sizes,
// table entry layout, FSM states and the size-to-mask helper.
// Entry field widths are fixed here and must match the ADDR_W / DATA_W /
// CYC_W parameters of mem_check_scoreboard.
package mem_check_pkg;

    localparam int ENTRY_ADDR_W = 32;
    localparam int ENTRY_DATA_W = 32;
    localparam int ENTRY_CYC_W  = 16;

    typedef enum logic [1:0] {
        SZ8  = 2'd0,
        SZ16 = 2'd1,
        SZ32 = 2'd2
    } check_size_e;

    typedef struct packed {
        logic [ENTRY_ADDR_W-1:0] addr;
        check_size_e             size;
        logic [ENTRY_DATA_W-1:0] value;
        logic [ENTRY_CYC_W-1:0]  clk;
    } check_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } chk_state_e;

    // Byte, halfword or full-word compare mask; anything else compares the full word.
    function automatic logic [ENTRY_DATA_W-1:0] size_mask(input check_size_e sz);
        logic [ENTRY_DATA_W-1:0] m;
        case (sz)
            SZ8:     m = {{(ENTRY_DATA_W-8){1'b0}}, 8'hFF};
            SZ16:    m = {{(ENTRY_DATA_W-16){1'b0}}, 16'hFFFF};
            default: m = '1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_check_scoreboard_table.sv
// Expectation table: NB_CHECKS entries, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module check_table
    import mem_check_pkg::*;
#(
    parameter int NB_CHECKS = 32
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [$clog2(NB_CHECKS)-1:0]  widx,
    input  check_entry_t                  wdata,
    input  logic [$clog2(NB_CHECKS)-1:0]  ridx,
    output check_entry_t                  rdata
);

    check_entry_t entries [NB_CHECKS];

    // Table load port.
    always_ff @(posedge clk) begin
        if (we) begin
            entries[widx] <= wdata;
        end
    end

    assign rdata = entries[ridx];

endmodule

// File: rtl/mem_check_scoreboard.sv
// Data-memory self-check scoreboard. Walks a loaded table of expectations,
// stalls the core at each due cycle, reads the memory word through a side
// port and compares it under a size mask, counting passes and failures.
// Optional macro MEM_CHECK_STOP_ON_FAIL_EN: stop at the first mismatch.
module mem_check_scoreboard
    import mem_check_pkg::*;
#(
    parameter int NB_CHECKS = 32,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int CYC_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ld_valid,
    input  logic [$clog2(NB_CHECKS)-1:0]  ld_idx,
    input  logic [ADDR_W-1:0]             ld_addr,
    input  logic [1:0]                    ld_size,
    input  logic [DATA_W-1:0]             ld_value,
    input  logic [CYC_W-1:0]              ld_clk,
    input  logic [$clog2(NB_CHECKS):0]    n_checks,
    input  logic                          start,
    output logic                          dut_hold,
    output logic [ADDR_W-1:0]             rd_addr,
    input  logic [DATA_W-1:0]             rd_data,
    output logic [CYC_W-1:0]              cycle,
    output logic [$clog2(NB_CHECKS):0]    pass_cnt,
    output logic [$clog2(NB_CHECKS):0]    fail_cnt,
    output logic [$clog2(NB_CHECKS)-1:0]  first_fail_idx,
    output logic                          done,
    output logic                          all_pass
);

    localparam int IDX_W = $clog2(NB_CHECKS);
    localparam int CNT_W = IDX_W + 1;

    chk_state_e         state;
    logic [IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]   n_chk_q;
    check_entry_t       wr_entry;
    check_entry_t       cur;
    logic               tbl_we;
    logic               due;
    logic               hit;
    logic               last;
    logic               finish;
    logic [DATA_W-1:0]  mask;

    // Normalise the loaded size code: 2 and 3 both mean a full-word compare.
    always_comb begin
        wr_entry.addr  = ld_addr;
        wr_entry.value = ld_value;
        wr_entry.clk   = ld_clk;
        case (ld_size)
            2'd0:    wr_entry.size = SZ8;
            2'd1:    wr_entry.size = SZ16;
            default: wr_entry.size = SZ32;
        endcase
    end

    assign tbl_we = (state == IDLE) && ld_valid;

    check_table #(
        .NB_CHECKS (NB_CHECKS)
    ) u_table (
        .clk   (clk),
        .we    (tbl_we),
        .widx  (ld_idx),
        .wdata (wr_entry),
        .ridx  (ptr),
        .rdata (cur)
    );

    // A late (unsorted) entry is caught by >= and simply checked immediately.
    assign due      = (state == RUN) && (cycle >= cur.clk);
    assign dut_hold = due || (state == CMP);
    // The address stays on the port through CMP; memory returns it one clock later.
    assign rd_addr  = dut_hold ? cur.addr : '0;
    assign mask     = size_mask(cur.size);
    assign hit      = ((rd_data ^ cur.value) & mask) == '0;
    assign last     = (CNT_W'(ptr) + CNT_W'(1)) == n_chk_q;
    assign all_pass = done && (fail_cnt == '0);

`ifdef MEM_CHECK_STOP_ON_FAIL_EN
    assign finish = last || !hit;
`else
    assign finish = last;
`endif

    // Scoreboard FSM with cycle counter, pointer and pass/fail bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            ptr            <= '0;
            n_chk_q        <= '0;
            cycle          <= '0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            done           <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_chk_q        <= n_checks;
                        cycle          <= '0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_idx <= '0;
                        ptr            <= '0;
                        if (n_checks == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            done  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (due) begin
                        state <= CMP;
                    end else if (!(&cycle)) begin
                        cycle <= cycle + CYC_W'(1);
                    end
                end
                CMP: begin
                    if (hit) begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                        if (fail_cnt == '0) begin
                            first_fail_idx <= ptr;
                        end
                    end
                    if (finish) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        ptr   <= ptr + IDX_W'(1);
                        state <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_check_scoreboard.sv
// Directed bench for mem_check_scoreboard with a synchronous-read memory model.
module tb_mem_check_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [4:0]  ld_idx;
    logic [31:0] ld_addr;
    logic [1:0]  ld_size;
    logic [31:0] ld_value;
    logic [15:0] ld_clk;
    logic [5:0]  n_checks;
    logic        start;
    logic        dut_hold;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [15:0] cycle;
    logic [5:0]  pass_cnt;
    logic [5:0]  fail_cnt;
    logic [4:0]  first_fail_idx;
    logic        done;
    logic        all_pass;

    logic [31:0] mem [64];

    int total = 0;
    int bad   = 0;
    int holds, first_c, last_c;
    int exp_pass, exp_fail, exp_holds;
    logic hold_seen;

    mem_check_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .ld_valid       (ld_valid),
        .ld_idx         (ld_idx),
        .ld_addr        (ld_addr),
        .ld_size        (ld_size),
        .ld_value       (ld_value),
        .ld_clk         (ld_clk),
        .n_checks       (n_checks),
        .start          (start),
        .dut_hold       (dut_hold),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .cycle          (cycle),
        .pass_cnt       (pass_cnt),
        .fail_cnt       (fail_cnt),
        .first_fail_idx (first_fail_idx),
        .done           (done),
        .all_pass       (all_pass)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr[5:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic load(input int idx, input int addr, input int sz, input logic [31:0] val, input int due);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_idx   = 5'(idx);
        ld_addr  = 32'(addr);
        ld_size  = 2'(sz);
        ld_value = val;
        ld_clk   = 16'(due);
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        n_checks = 6'(n);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Sample at negedges until done, recording stall length and the cycle seen while stalled.
    task automatic run_to_done(input int budget, output int h, output int fc, output int lc);
        h = 0; fc = -1; lc = -1;
        for (int i = 0; i < budget && !done; i++) begin
            if (dut_hold) begin
                if (h == 0) fc = int'(cycle);
                lc = int'(cycle);
                h++;
            end
            @(negedge clk);
        end
        check("done_reached", done, 1);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; ld_valid = 1'b0; ld_idx = '0; ld_addr = '0;
        ld_size = '0; ld_value = '0; ld_clk = '0; n_checks = '0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[22] = 32'h0000001E;
        mem[4]  = 32'hF0F0F0F1;
        mem[16] = 32'hABCD0002;
        mem[1]  = 32'h11111111;
        mem[2]  = 32'h123456AB;
        mem[3]  = 32'h99995678;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pass", pass_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_done", done, 0);
        check("rst_allpass", all_pass, 0);
        check("rst_hold", dut_hold, 0);
        check("rst_rdaddr", rd_addr, 0);
        check("rst_ffi", first_fail_idx, 0);
        check("rst_cycle", cycle, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single full-word check at cycle 26
        load(0, 22, 2, 32'h0000001E, 26);
        do_start(1);
        run_to_done(1000, holds, first_c, last_c);
        check("t1_holds", holds, 2);
        check("t1_hold_cycle", first_c, 26);
        check("t1_pass", pass_cnt, 1);
        check("t1_fail", fail_cnt, 0);
        check("t1_allpass", all_pass, 1);
        check("t1_cycle_end", cycle, 26);

        // Two entries due at the same cycle, second with size code 3
        do_reset();
        load(0, 4, 2, 32'hF0F0F0F1, 326);
        load(1, 4, 3, 32'hF0F0F0F1, 326);
        do_start(2);
        run_to_done(1000, holds, first_c, last_c);
        check("t2_holds", holds, 4);
        check("t2_first_cycle", first_c, 326);
        check("t2_last_cycle", last_c, 326);
        check("t2_pass", pass_cnt, 2);
        check("t2_cycle_end", cycle, 326);

        // Halfword compare masks the upper half
        do_reset();
        load(0, 16, 1, 32'h00000002, 5);
        do_start(1);
        run_to_done(1000, holds, first_c, last_c);
        check("t3a_pass", pass_cnt, 1);
        check("t3a_fail", fail_cnt, 0);
        check("t3a_allpass", all_pass, 1);

        // Same entry as a full word mismatches
        do_reset();
        load(0, 16, 2, 32'h00000002, 5);
        do_start(1);
        run_to_done(1000, holds, first_c, last_c);
        check("t3b_pass", pass_cnt, 0);
        check("t3b_fail", fail_cnt, 1);
        check("t3b_ffi", first_fail_idx, 0);
        check("t3b_allpass", all_pass, 0);

        // Three entries, byte compare on entry 1 mismatches (0xAB vs 0xAA)
        do_reset();
        load(0, 1, 2, 32'h11111111, 3);
        load(1, 2, 0, 32'h000000AA, 5);
        load(2, 3, 1, 32'h00005678, 8);
        do_start(3);
        run_to_done(1000, holds, first_c, last_c);
`ifdef MEM_CHECK_STOP_ON_FAIL_EN
        exp_pass = 1; exp_fail = 1; exp_holds = 4;
`else
        exp_pass = 2; exp_fail = 1; exp_holds = 6;
`endif
        check("t4_pass", pass_cnt, 64'(exp_pass));
        check("t4_fail", fail_cnt, 64'(exp_fail));
        check("t4_holds", holds, 64'(exp_holds));
        check("t4_ffi", first_fail_idx, 1);
        check("t4_allpass", all_pass, 0);

        // Async reset during the compare of entry 2
        do_reset();
        load(0, 1, 2, 32'h11111111, 3);
        load(1, 2, 0, 32'h000000AB, 5);
        load(2, 3, 1, 32'h00005678, 8);
        do_start(3);
        holds = 0;
        for (int i = 0; i < 1000 && holds < 6; i++) begin
            if (dut_hold) holds++;
            if (holds < 6) @(negedge clk);
        end
        check("t5_reached_cmp2", holds, 6);
        rst = 1'b0;
        #1;
        check("t5_hold_rel", dut_hold, 0);
        check("t5_rdaddr", rd_addr, 0);
        check("t5_pass_clr", pass_cnt, 0);
        check("t5_done_clr", done, 0);
        check("t5_cycle_clr", cycle, 0);
        @(negedge clk);
        rst = 1'b1;
        load(0, 1, 2, 32'h11111111, 3);
        load(1, 2, 0, 32'h000000AB, 5);
        load(2, 3, 1, 32'h00005678, 8);
        do_start(3);
        run_to_done(1000, holds, first_c, last_c);
        check("t5_pass", pass_cnt, 3);
        check("t5_fail", fail_cnt, 0);
        check("t5_allpass", all_pass, 1);

        // n_checks = 0 re-armed from DONE
        do_start(0);
        check("t6_done", done, 1);
        check("t6_allpass", all_pass, 1);
        check("t6_pass_clr", pass_cnt, 0);
        hold_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (dut_hold) hold_seen = 1'b1;
            @(negedge clk);
        end
        check("t6_no_hold", hold_seen, 0);

        // ld_valid during RUN must not alter the table
        do_reset();
        load(0, 1, 2, 32'h11111111, 3);
        do_start(1);
        load(0, 5, 2, 32'hDEADBEEF, 0);
        run_to_done(1000, holds, first_c, last_c);
        check("t7_pass", pass_cnt, 1);
        check("t7_fail", fail_cnt, 0);
        do_start(1);
        run_to_done(1000, holds, first_c, last_c);
        check("t7_rearm_pass", pass_cnt, 1);
        check("t7_rearm_fail", fail_cnt, 0);
        check("t7_rearm_cycle", cycle, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_check_scoreboard.md
Name: mem_check_scoreboard

Overview:
- Synthesizable self-check scoreboard for the RISC-V core's data memory. Generalises the fixed per-cycle expected-value checks into a parametrised, loadable table.
- Holds up to NB_CHECKS expectations, each an address, size, value and due cycle.
- At each due cycle it stalls the DUT, reads the memory word through a side read port, compares under a size mask, and counts passes and failures.
- Sits beside riscv/mem in benches and FPGA self-test tops; drives the core's stall input.

Parameters:
- NB_CHECKS, 32, table depth (max expectations)
- ADDR_W, 32, data-memory word-index width
- DATA_W, 32, data word width
- CYC_W, 16, cycle counter / due-cycle width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- ld_valid  in  1  write one table entry (IDLE only)
- ld_idx  in  $clog2(NB_CHECKS)  entry index
- ld_addr  in  ADDR_W  memory word index to check
- ld_size  in  2  compare width: 0=8b, 1=16b, 2=32b, 3=32b
- ld_value  in  DATA_W  expected value
- ld_clk  in  CYC_W  due cycle (entries sorted ascending)
- n_checks  in  $clog2(NB_CHECKS)+1  number of valid entries, sampled on start
- start  in  1  pulse: IDLE->RUN, cycle counter cleared to 0
- dut_hold  out  1  stall request to core (combinational)
- rd_addr  out  ADDR_W  side read address to data memory (combinational)
- rd_data  in  DATA_W  memory data, 1-cycle synchronous read latency
- cycle  out  CYC_W  DUT cycles elapsed since start
- pass_cnt  out  $clog2(NB_CHECKS)+1  passed checks
- fail_cnt  out  $clog2(NB_CHECKS)+1  failed checks
- first_fail_idx  out  $clog2(NB_CHECKS)  index of first mismatch
- done  out  1  all checks evaluated
- all_pass  out  1  done && fail_cnt==0

Behaviour:
- Reset values:
  - Outputs: all counters 0, done=0, all_pass=0, first_fail_idx=0, dut_hold=0, rd_addr=0.
  - State: IDLE, ptr=0.
  - Table contents are not reset.
- States: IDLE, RUN, CMP, DONE.
- IDLE:
  - ld_valid writes entry[ld_idx]; ld_valid is ignored in every other state.
  - start latches n_checks, clears cycle/pass/fail/ptr/done, and moves to RUN.
  - start with n_checks==0 goes directly to DONE with all_pass=1.
- RUN:
  - cycle increments every clock in which dut_hold=0.
  - due = (cycle >= entry[ptr].clk). When due: dut_hold=1, rd_addr=entry[ptr].addr, next state CMP, cycle frozen.
- CMP:
  - dut_hold=1.
  - mask = 0xFF, 0xFFFF or all-ones per size. Pass if (rd_data & mask) == (value & mask).
  - Increment pass_cnt or fail_cnt. On the first failure, record first_fail_idx=ptr.
  - ptr++. If ptr+1 == n_checks, go to DONE; else go to RUN.
  - RUN re-evaluates the next entry at the same frozen cycle, so entries with equal due cycles are checked back-to-back without DUT progress.
- Cost per check: 2 clocks of DUT stall. The DUT state checked is exactly the state at the due cycle.
- DONE:
  - done=1, dut_hold=0, counters hold.
  - start re-arms (same behaviour as from IDLE); ld_valid is ignored until then.
- Unsorted entries: a due cycle already passed is detected immediately via >=. The check runs late, with no error flag.
- Wrap: cycle saturates at all-ones. It does not wrap.
- start during RUN/CMP is ignored.
- Async reset mid-run: immediate return to IDLE, hold released.

Optional Feature:
- Macro MEM_CHECK_STOP_ON_FAIL_EN.
- Defined: the first mismatch in CMP goes straight to DONE. Remaining entries are not evaluated, and pass_cnt+fail_cnt < n_checks.
- Undefined: all n_checks entries are always evaluated.

Decomposition:
- Package mem_check_pkg:
  - check_size_e (SZ8, SZ16, SZ32)
  - check_entry_t struct {addr, size, value, clk}
  - chk_state_e (IDLE, RUN, CMP, DONE)
  - function size_mask(check_size_e) returning DATA_W mask
- Sub-module check_table: NB_CHECKS x check_entry_t register array, one write port and one async read port indexed by ptr.
- The top keeps the FSM, counters and compare logic.

Test Plan:
- Load 1 entry {addr 22, SZ32, 0x0000001E, clk 26}; memory model holds 0x1E at cycle 26 -> dut_hold high for exactly 2 clocks at cycle=26, pass_cnt=1, done=1, all_pass=1.
- Two entries both due at clk 326, addr 4, 0xF0F0F0F1 -> checked back-to-back, cycle stays 326 for 4 clocks, pass_cnt=2.
- Entry {addr 16, SZ16, 0x00000002}; memory holds 0xABCD0002 -> pass (upper half masked). Same with SZ32 -> fail_cnt=1, first_fail_idx=0, all_pass=0.
- 3 entries, entry 1 mismatches: without macro -> pass 2 / fail 1. With MEM_CHECK_STOP_ON_FAIL_EN -> pass 1 / fail 1, done right after entry 1.
- rst asserted low during CMP of entry 2 -> dut_hold=0 and IDLE immediately, counters 0. Reload and restart give correct results.
- start with n_checks=0 -> done=1, all_pass=1, dut_hold never asserted; ld_valid during RUN leaves the table unchanged.
